tile_stream_scheduler: RTL and testbench

//  Sequences the 4x4 systolic brightness array over a whole image held in pixel RAM.
//  Per tile: fetches NxN pixels, loads the gain weights once, streams skewed columns with a

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/skew_tile_buffer.sv | 47 ++++
 rtl/tile_stream_scheduler.sv | 173 +++++++++++++++++
 tb/tb_tile_stream_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the tile stream scheduler.
// Imported by the scheduler top and its tile buffer.
package systolic_pkg;

    localparam int N_DEF     = 4;
    localparam int DW_DEF    = 8;
    localparam int WW_DEF    = 16;
    localparam int AW_DEF    = 12;
    localparam int DRAIN_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/skew_tile_buffer.sv
// NxN pixel tile store with a row/col write port and a
// skewed read port: lane i of beat t is buf[t-i][i], else 0.
module skew_tile_buffer
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    localparam int RW = (N > 1) ? $clog2(N) : 1,
    localparam int TW = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en_i,
    input  logic [RW-1:0]   wr_row_i,
    input  logic [RW-1:0]   wr_col_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic [TW-1:0]   beat_i,
    output logic [N*DW-1:0] lanes_o
);

    logic [DW-1:0] mem_q [N][N];

    // Pixel storage, cleared on reset, written one byte per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    // Diagonal read: lane i lags lane 0 by i beats, zero outside the tile.
    always_comb begin
        lanes_o = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(beat_i) >= i && int'(beat_i) - i < N) begin
                lanes_o[i*DW +: DW] =
                    mem_q[RW'(int'(beat_i) - i)][RW'(i)];
            end
        end
    end

endmodule

// File: rtl/tile_stream_scheduler.sv
// Walks an image in pixel RAM tile by tile: fetch, one-time
// weight load, skewed stream to the systolic array, drain.
module tile_stream_scheduler
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int WW    = WW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DRAIN = DRAIN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-5:0]   num_tiles,
    input  logic [N*WW-1:0] gain_wt,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_en,
    input  logic [DW-1:0]   mem_data,
    output logic            wt_load,
    output logic [N*WW-1:0] wt_arr,
    output logic            tpu_valid,
    input  logic            tpu_ready,
    output logic [N*DW-1:0] data_arr,
    output logic            busy,
    output logic            done
);

    localparam int NN  = N * N;
    localparam int KW  = $clog2(NN + 1);
    localparam int IW  = $clog2(NN);
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int TW  = $clog2(2 * N);
    localparam int TCW = AW - 4;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [KW-1:0]  K_LAST    = KW'(NN);
    localparam logic [TW-1:0]  T_LAST    = TW'(2 * N - 2);
    localparam logic [DCW-1:0] D_LAST    = DCW'(DRAIN - 1);
    localparam logic [AW-1:0]  BASE_STEP = AW'(NN);
    localparam logic [TCW-1:0] TILE_ONE  = TCW'(1);

    sched_state_t    state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DCW-1:0]  dc_q, dc_d;
    logic [TCW-1:0]  tile_q, tile_d;
    logic [TCW-1:0]  ntiles_q, ntiles_d;
    logic [N*WW-1:0] gain_q, gain_d;
    logic            pend_q;
    logic [IW-1:0]   pidx_q;
    logic [N*DW-1:0] buf_lanes;

    // Read data lands one cycle after issue; N is a power of two,
    // so the fetch index splits directly into row and column.
    skew_tile_buffer #(
        .N (N),
        .DW(DW)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (pend_q),
        .wr_row_i (pidx_q[IW-1:RW]),
        .wr_col_i (pidx_q[RW-1:0]),
        .wr_data_i(mem_data),
        .beat_i   (t_q),
        .lanes_o  (buf_lanes)
    );

    // State, counters and job latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            k_q      <= '0;
            t_q      <= '0;
            dc_q     <= '0;
            tile_q   <= '0;
            ntiles_q <= '0;
            gain_q   <= '0;
            pend_q   <= 1'b0;
            pidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            k_q      <= k_d;
            t_q      <= t_d;
            dc_q     <= dc_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            gain_q   <= gain_d;
            pend_q   <= mem_en;
            pidx_q   <= k_q[IW-1:0];
        end
    end

    // Next-state sequencing and Moore outputs.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        k_d       = k_q;
        t_d       = t_q;
        dc_d      = dc_q;
        tile_d    = tile_q;
        ntiles_d  = ntiles_q;
        gain_d    = gain_q;
        mem_en    = 1'b0;
        mem_addr  = '0;
        wt_load   = 1'b0;
        wt_arr    = '0;
        tpu_valid = 1'b0;
        data_arr  = '0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ntiles_d = num_tiles;
                    gain_d   = gain_wt;
                    base_d   = '0;
                    tile_d   = '0;
                    k_d      = '0;
                    state_d  = (num_tiles == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    t_d     = '0;
                    state_d = (tile_q == '0) ? S_WLOAD : S_STREAM;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + AW'(k_q);
                    k_d      = k_q + KW'(1);
                end
            end
            S_WLOAD: begin
                wt_load = 1'b1;
                wt_arr  = gain_q;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                tpu_valid = 1'b1;
                data_arr  = buf_lanes;
                if (tpu_ready) begin
                    if (t_q == T_LAST) begin
                        dc_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (dc_q == D_LAST) begin
                    tile_d  = tile_q + TILE_ONE;
                    base_d  = base_q + BASE_STEP;
                    state_d = (tile_q + TILE_ONE == ntiles_q)
                              ? S_FIN : S_FETCH;
                end else begin
                    dc_d = dc_q + DCW'(1);
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tile_stream_scheduler.sv
// Directed bench for tile_stream_scheduler with a behavioural
// pixel RAM (RAM[a] = a+1) and cycle-accurate expectations.
module tb_tile_stream_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WW = 16;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [AW-5:0]   num_tiles = '0;
    logic [N*WW-1:0] gain_wt = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_en;
    logic [DW-1:0]   mem_data = '0;
    logic            wt_load;
    logic [N*WW-1:0] wt_arr;
    logic            tpu_valid;
    logic            tpu_ready = 1'b1;
    logic [N*DW-1:0] data_arr;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  ram [4096];
    logic [31:0] exp0 [7] = '{
        32'h0000_0001, 32'h0000_0205, 32'h0003_0609,
        32'h0407_0A0D, 32'h080B_0E00, 32'h0C0F_0000,
        32'h1000_0000
    };

    int          n_acc = 0;
    int          n_wt = 0;
    int          n_done = 0;
    int          n_mem = 0;
    int          n_val = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0] acc_log [128];

    localparam logic [63:0] G1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] G2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] G3 = 64'h0102_0304_0506_0708;

    tile_stream_scheduler #(
        .N    (N),
        .DW   (DW),
        .WW   (WW),
        .AW   (AW),
        .DRAIN(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_tiles(num_tiles),
        .gain_wt  (gain_wt),
        .mem_addr (mem_addr),
        .mem_en   (mem_en),
        .mem_data (mem_data),
        .wt_load  (wt_load),
        .wt_arr   (wt_arr),
        .tpu_valid(tpu_valid),
        .tpu_ready(tpu_ready),
        .data_arr (data_arr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM model plus event monitors.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_data  <= ram[mem_addr];
            n_mem     <= n_mem + 1;
            last_addr <= mem_addr;
        end
        if (tpu_valid) n_val <= n_val + 1;
        if (tpu_valid && tpu_ready) begin
            if (n_acc < 128) acc_log[n_acc] <= data_arr;
            n_acc <= n_acc + 1;
        end
        if (wt_load) n_wt <= n_wt + 1;
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [31:0] exp_beat(input int t, input int j);
        logic [31:0] v;
        v = exp0[t];
        for (int i = 0; i < 4; i++) begin
            if (v[i*8 +: 8] != 8'd0) v[i*8 +: 8] = v[i*8 +: 8] + 8'(16 * j);
        end
        return v;
    endfunction

    task automatic stream_check(input int j, input bit stall);
        for (int t = 0; t < 7; t++) begin
            int ns;
            ns = (stall && (t == 2 || t == 5)) ? 3 : 0;
            for (int s = 0; s < ns; s++) begin
                tpu_ready = 1'b0;
                chk("stall_valid", 64'(tpu_valid), 64'd1);
                chk("stall_data", 64'(data_arr), 64'(exp_beat(t, j)));
                tick(1);
            end
            tpu_ready = 1'b1;
            chk("beat_valid", 64'(tpu_valid), 64'd1);
            chk("beat_data", 64'(data_arr), 64'(exp_beat(t, j)));
            tick(1);
        end
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick(1);
            k++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int w0, a0, d0, m0, v0;
        for (int a = 0; a < 4096; a++) ram[a] = 8'(a + 1);

        // Reset state
        tick(2);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_wt_load", 64'(wt_load), 64'd0);
        chk("rst_wt_arr", wt_arr, 64'd0);
        chk("rst_valid", 64'(tpu_valid), 64'd0);
        chk("rst_data", 64'(data_arr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick(1);

        // Single tile, ready held high
        w0 = n_wt; a0 = n_acc;
        num_tiles = 8'd1; gain_wt = G1; start = 1'b1; cyc = 0;
        tick(1);
        start = 1'b0;
        chk("t1_mem_en", 64'(mem_en), 64'd1);
        chk("t1_addr0", 64'(mem_addr), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        tick(5);
        chk("t1_addr5", 64'(mem_addr), 64'd5);
        tick(11);
        chk("t1_fetch_tail", 64'(mem_en), 64'd0);
        tick(1);
        chk("t1_wt_load", 64'(wt_load), 64'd1);
        chk("t1_wt_arr", wt_arr, G1);
        chk("t1_wload_noval", 64'(tpu_valid), 64'd0);
        tick(1);
        stream_check(0, 1'b0);
        chk("t1_drain_valid", 64'(tpu_valid), 64'd0);
        chk("t1_drain_data", 64'(data_arr), 64'd0);
        wait_done(20);
        chk("t1_done_cycle", 64'(cyc), 64'd30);
        chk("t1_done_busy", 64'(busy), 64'd1);
        tick(1);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_busy_off", 64'(busy), 64'd0);
        chk("t1_wt_count", 64'(n_wt - w0), 64'd1);
        chk("t1_beats", 64'(n_acc - a0), 64'd7);

        // Backpressure on beats 2 and 5
        a0 = n_acc;
        num_tiles = 8'd1; gain_wt = G1; start = 1'b1; cyc = 0;
        tick(1);
        start = 1'b0;
        tick(18);
        stream_check(0, 1'b1);
        wait_done(20);
        chk("bp_done_cycle", 64'(cyc), 64'd36);
        tick(1);
        chk("bp_beats", 64'(n_acc - a0), 64'd7);
        for (int b = 0; b < 7; b++)
            chk("bp_log", 64'(acc_log[a0 + b]), 64'(exp_beat(b, 0)));

        // Three tiles, plus a start pulse while busy
        w0 = n_wt; a0 = n_acc; d0 = n_done; m0 = n_mem;
        num_tiles = 8'd3; gain_wt = G1; start = 1'b1; cyc = 0;
        tick(1);
        start = 1'b0;
        tick(4);
        start = 1'b1; num_tiles = 8'd7; gain_wt = G2;
        tick(1);
        start = 1'b0; num_tiles = 8'd0;
        tick(12);
        chk("m3_wt_load", 64'(wt_load), 64'd1);
        chk("m3_wt_arr", wt_arr, G1);
        wait_done(100);
        chk("m3_done_cycle", 64'(cyc), 64'd86);
        tick(1);
        chk("m3_busy_off", 64'(busy), 64'd0);
        chk("m3_wt_count", 64'(n_wt - w0), 64'd1);
        chk("m3_done_count", 64'(n_done - d0), 64'd1);
        chk("m3_beats", 64'(n_acc - a0), 64'd21);
        chk("m3_mem_count", 64'(n_mem - m0), 64'd48);
        chk("m3_last_addr", 64'(last_addr), 64'd47);
        for (int b = 0; b < 21; b++)
            chk("m3_log", 64'(acc_log[a0 + b]), 64'(exp_beat(b % 7, b / 7)));

        // Zero-tile job; start held into FIN is ignored
        m0 = n_mem; v0 = n_val;
        num_tiles = 8'd0; gain_wt = G2; start = 1'b1; cyc = 0;
        tick(1);
        chk("z_done", 64'(done), 64'd1);
        chk("z_busy", 64'(busy), 64'd1);
        tick(1);
        start = 1'b0;
        chk("z_done_off", 64'(done), 64'd0);
        chk("z_busy_off", 64'(busy), 64'd0);
        tick(2);
        chk("z_no_mem", 64'(n_mem - m0), 64'd0);
        chk("z_no_valid", 64'(n_val - v0), 64'd0);

        // Reset during the second tile's stream
        num_tiles = 8'd3; gain_wt = G1; start = 1'b1; cyc = 0;
        tick(1);
        start = 1'b0;
        tick(48);
        chk("r_pre_valid", 64'(tpu_valid), 64'd1);
        d0 = n_done;
        reset = 1'b1;
        #1;
        chk("r_valid", 64'(tpu_valid), 64'd0);
        chk("r_data", 64'(data_arr), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_mem_en", 64'(mem_en), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("r_no_done", 64'(n_done - d0), 64'd0);
        w0 = n_wt;
        num_tiles = 8'd1; gain_wt = G3; start = 1'b1; cyc = 0;
        tick(1);
        start = 1'b0;
        chk("r_restart_en", 64'(mem_en), 64'd1);
        chk("r_restart_addr", 64'(mem_addr), 64'd0);
        tick(17);
        chk("r_wt_arr", wt_arr, G3);
        wait_done(40);
        chk("r_done_cycle", 64'(cyc), 64'd30);
        chk("r_wt_count", 64'(n_wt - w0), 64'd1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
